bcd_7segment: RTL and testbench
===============================

Name: bcd_7segment

Overview:
- Registered BCD-to-7-segment decoder for a single digit of a display driver.
- Converts a 4-bit BCD code into segment drives a..g.
- Provides lamp-test, blanking, ripple-blanking for leading-zero suppression, and an invalid-code flag.
- Sits between the digit-select/mux logic and the display pad drivers.

Parameters:
- ACTIVE_LOW, 0, 1 = all segment outputs (a..g) are inverted at the register input for common-anode displays; 0 = segment lit drives 1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  4  BCD digit code
- lt  input  1  lamp test, lights all segments
- bi  input  1  blank, turns all segments off
- rbi  input  1  ripple-blank in; blank the digit when din==0
- rbo  output  1  ripple-blank out; 1 when this digit was ripple-blanked
- err  output  1  1 when din is not a valid BCD code (10..15)
- a, b, c, d, e, f, g  output  1 each  segment drives (standard a=top, clockwise, g=middle)

Behaviour:
- One clock is used. Reset is asynchronous and active-high.
- All outputs are registered, with 1-cycle latency: inputs sampled at edge N appear on outputs after edge N.
- Reset (async assert, sync to clk on deassert edge not required):
  - segments go to the "off" level (0 if ACTIVE_LOW=0, 1 if ACTIVE_LOW=1);
  - rbo=0, err=0.
- Decode table, active-high pattern abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Invalid codes 10..15: all segments off, err=1. err=0 for 0..9.
- Priority, highest first:
  - lt: all segments on, rbo=0; err still reflects din.
  - bi: all segments off, rbo=0.
  - rbi && din==0: all segments off, rbo=1.
  - otherwise: normal decode, rbo=0.
- err is computed from din independently of lt/bi/rbi.
- ACTIVE_LOW inverts only a..g; rbo and err are always active-high.
- Simultaneous lt and bi: lt wins.
- Reset asserted mid-operation forces reset values immediately. The first decode appears after the first rising edge following deassertion.
- There is no other state. Outputs hold their last value while inputs are stable.

Optional Feature:
- Macro: BCD_7SEGMENT_HEX_DIGITS_EN.
- When defined, codes 10..15 decode to hex glyphs and err is always 0:
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- lt/bi/rbi priority is unchanged. rbi blanking still applies only to din==0.
- When undefined, codes 10..15 blank all segments and set err=1 as above.

Test Plan:
- Reset check: assert rst with din=8 -> a..g=0000000, rbo=0, err=0 immediately, with no clock edge needed. Deassert rst, then one edge later -> 1111111.
- Sweep: lt=bi=rbi=0, din=0..9, one per cycle -> each pattern from the table appears exactly one cycle after its din (e.g. din=2 -> 1101101, din=7 -> 1110000), err=0.
- Invalid codes: din=10..15 -> a..g=0000000, err=1 (without macro). With BCD_7SEGMENT_HEX_DIGITS_EN, din=11 -> 0011111, err=0.
- Control priority:
  - lt=1, bi=1, din=1 -> 1111111.
  - lt=0, bi=1, din=8 -> 0000000, rbo=0.
  - rbi=1, din=0 -> 0000000, rbo=1.
  - rbi=1, din=5 -> 1011011, rbo=0.
- ACTIVE_LOW=1: reset -> a..g=1111111. din=0 -> 0000001, din=1 -> 1001111. rbo/err polarity unchanged.
- Mid-run reset: assert rst asynchronously between edges while din=9 -> outputs go off before the next edge. After release, din=3 -> 1111001 one cycle later.

Source files
------------

// File: rtl/bcd_7segment.sv
// Registered BCD-to-7-segment decoder with lamp test, blanking, ripple blanking and invalid-code flag.
// Optional build macro BCD_7SEGMENT_HEX_DIGITS_EN turns codes 10..15 into hex glyphs A,b,C,d,E,F.
module bcd_7segment #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       lt,
  input  logic       bi,
  input  logic       rbi,
  output logic       rbo,
  output logic       err,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  // Segment vectors are ordered {a,b,c,d,e,f,g}, bit 6 = a.
  logic [6:0] w_glyph;
  logic [6:0] w_seg;
  logic       w_rbo;
  logic       w_err;
  logic [6:0] r_seg;
  logic       r_rbo;
  logic       r_err;

  always_comb begin
    w_glyph = 7'b0000000;
    case (din)
      4'd0:    w_glyph = 7'b1111110;
      4'd1:    w_glyph = 7'b0110000;
      4'd2:    w_glyph = 7'b1101101;
      4'd3:    w_glyph = 7'b1111001;
      4'd4:    w_glyph = 7'b0110011;
      4'd5:    w_glyph = 7'b1011011;
      4'd6:    w_glyph = 7'b1011111;
      4'd7:    w_glyph = 7'b1110000;
      4'd8:    w_glyph = 7'b1111111;
      4'd9:    w_glyph = 7'b1111011;
`ifdef BCD_7SEGMENT_HEX_DIGITS_EN
      4'd10:   w_glyph = 7'b1110111;
      4'd11:   w_glyph = 7'b0011111;
      4'd12:   w_glyph = 7'b1001110;
      4'd13:   w_glyph = 7'b0111101;
      4'd14:   w_glyph = 7'b1001111;
      4'd15:   w_glyph = 7'b1000111;
`endif
      default: w_glyph = 7'b0000000;
    endcase
  end

`ifdef BCD_7SEGMENT_HEX_DIGITS_EN
  assign w_err = 1'b0;
`else
  assign w_err = (din > 4'd9);
`endif

  // Lamp test beats blank, blank beats ripple blanking; err ignores all three.
  always_comb begin
    w_seg = w_glyph;
    w_rbo = 1'b0;
    if (lt) begin
      w_seg = 7'b1111111;
    end else if (bi) begin
      w_seg = 7'b0000000;
    end else if (rbi && (din == 4'd0)) begin
      w_seg = 7'b0000000;
      w_rbo = 1'b1;
    end
  end

  // Polarity is applied before the register so the pads see a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= {7{ACTIVE_LOW}};
      r_rbo <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_seg <= w_seg ^ {7{ACTIVE_LOW}};
      r_rbo <= w_rbo;
      r_err <= w_err;
    end
  end

  assign {a, b, c, d, e, f, g} = r_seg;
  assign rbo = r_rbo;
  assign err = r_err;

endmodule

// File: tb/tb_bcd_7segment.sv
// Directed bench for bcd_7segment: one active-high and one active-low instance share the same inputs.
module tb_bcd_7segment;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = 4'd8;
  logic       lt  = 1'b0;
  logic       bi  = 1'b0;
  logic       rbi = 1'b0;

  logic rbo_h, err_h, a_h, b_h, c_h, d_h, e_h, f_h, g_h;
  logic rbo_l, err_l, a_l, b_l, c_l, d_l, e_l, f_l, g_l;
  logic [6:0] seg_h;
  logic [6:0] seg_l;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-written expected glyphs, {a..g}, active-high.
  logic [6:0] exp_dec [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  logic [6:0] exp_hex [6]  = '{7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111,
                               7'b1000111};

  assign seg_h = {a_h, b_h, c_h, d_h, e_h, f_h, g_h};
  assign seg_l = {a_l, b_l, c_l, d_l, e_l, f_l, g_l};

  bcd_7segment #(.ACTIVE_LOW(1'b0)) u_dut_h (
    .clk(clk), .rst(rst), .din(din), .lt(lt), .bi(bi), .rbi(rbi),
    .rbo(rbo_h), .err(err_h),
    .a(a_h), .b(b_h), .c(c_h), .d(d_h), .e(e_h), .f(f_h), .g(g_h)
  );

  bcd_7segment #(.ACTIVE_LOW(1'b1)) u_dut_l (
    .clk(clk), .rst(rst), .din(din), .lt(lt), .bi(bi), .rbi(rbi),
    .rbo(rbo_l), .err(err_l),
    .a(a_l), .b(b_l), .c(c_l), .d(d_l), .e(e_l), .f(f_l), .g(g_l)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    din = 4'd8; lt = 1'b0; bi = 1'b0; rbi = 1'b0; rst = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (seg_h !== 7'b0000000) begin n_err++; $display("FAIL reset_seg_h got %b want 0000000", seg_h); end
    n_cmp++;
    if (seg_l !== 7'b1111111) begin n_err++; $display("FAIL reset_seg_l got %b want 1111111", seg_l); end
    n_cmp++;
    if ({rbo_h, err_h, rbo_l, err_l} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got %b want 0000", {rbo_h, err_h, rbo_l, err_l});
    end
    @(negedge clk) rst = 1'b0;
    n_cmp++;
    if (seg_h !== 7'b0000000) begin n_err++; $display("FAIL reset_release_hold got %b want 0000000", seg_h); end
    tick();
    n_cmp++;
    if (seg_h !== 7'b1111111) begin n_err++; $display("FAIL reset_first_decode got %b want 1111111", seg_h); end
  endtask

  task automatic test_sweep();
    lt = 1'b0; bi = 1'b0; rbi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din = 4'(i);
      tick();
      n_cmp++;
      if (seg_h !== exp_dec[i] || err_h !== 1'b0 || rbo_h !== 1'b0) begin
        n_err++;
        $display("FAIL sweep din=%0d got seg=%b err=%b rbo=%b want seg=%b err=0 rbo=0",
                 i, seg_h, err_h, rbo_h, exp_dec[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [6:0] want_seg;
    logic       want_err;
    lt = 1'b0; bi = 1'b0; rbi = 1'b0;
    for (int i = 10; i < 16; i++) begin
      din = 4'(i);
`ifdef BCD_7SEGMENT_HEX_DIGITS_EN
      want_seg = exp_hex[i-10];
      want_err = 1'b0;
`else
      want_seg = 7'b0000000;
      want_err = 1'b1;
`endif
      tick();
      n_cmp++;
      if (seg_h !== want_seg || err_h !== want_err) begin
        n_err++;
        $display("FAIL invalid din=%0d got seg=%b err=%b want seg=%b err=%b",
                 i, seg_h, err_h, want_seg, want_err);
      end
    end
  endtask

  task automatic test_priority();
    // {lt, bi, rbi, din} -> expected {seg, rbo}
    logic [6:0] v_in   [8] = '{7'b110_0001, 7'b100_1100, 7'b010_1000, 7'b011_0000,
                               7'b001_0000, 7'b001_0101, 7'b101_0000, 7'b000_0000};
    logic [6:0] v_seg  [8] = '{7'b1111111, 7'b1111111, 7'b0000000, 7'b0000000,
                               7'b0000000, 7'b1011011, 7'b1111111, 7'b1111110};
    logic       v_rbo  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       want_err;
    for (int i = 0; i < 8; i++) begin
      {lt, bi, rbi, din} = v_in[i];
`ifdef BCD_7SEGMENT_HEX_DIGITS_EN
      want_err = 1'b0;
`else
      want_err = (v_in[i][3:0] > 4'd9);
`endif
      tick();
      n_cmp++;
      if (seg_h !== v_seg[i] || rbo_h !== v_rbo[i] || err_h !== want_err) begin
        n_err++;
        $display("FAIL priority vec=%0d got seg=%b rbo=%b err=%b want seg=%b rbo=%b err=%b",
                 i, seg_h, rbo_h, err_h, v_seg[i], v_rbo[i], want_err);
      end
    end
    lt = 1'b0; bi = 1'b0; rbi = 1'b0;
  endtask

  task automatic test_active_low();
    din = 4'd0;
    tick();
    n_cmp++;
    if (seg_l !== 7'b0000001) begin n_err++; $display("FAIL active_low_0 got %b want 0000001", seg_l); end
    din = 4'd1;
    tick();
    n_cmp++;
    if (seg_l !== 7'b1001111) begin n_err++; $display("FAIL active_low_1 got %b want 1001111", seg_l); end
    rbi = 1'b1; din = 4'd0;
    tick();
    n_cmp++;
    if (seg_l !== 7'b1111111 || rbo_l !== 1'b1) begin
      n_err++; $display("FAIL active_low_rbo got seg=%b rbo=%b want seg=1111111 rbo=1", seg_l, rbo_l);
    end
    rbi = 1'b0; din = 4'd13;
    tick();
    n_cmp++;
`ifdef BCD_7SEGMENT_HEX_DIGITS_EN
    if (seg_l !== 7'b1000010 || err_l !== 1'b0) begin
      n_err++; $display("FAIL active_low_err got seg=%b err=%b want seg=1000010 err=0", seg_l, err_l);
    end
`else
    if (seg_l !== 7'b1111111 || err_l !== 1'b1) begin
      n_err++; $display("FAIL active_low_err got seg=%b err=%b want seg=1111111 err=1", seg_l, err_l);
    end
`endif
  endtask

  task automatic test_back_to_back();
    // Outputs must not move until the edge after an input change, then hold.
    din = 4'd4;
    tick();
    din = 4'd6;
    #3;
    n_cmp++;
    if (seg_h !== 7'b0110011) begin n_err++; $display("FAIL latency_before_edge got %b want 0110011", seg_h); end
    tick();
    n_cmp++;
    if (seg_h !== 7'b1011111) begin n_err++; $display("FAIL latency_after_edge got %b want 1011111", seg_h); end
    tick();
    tick();
    n_cmp++;
    if (seg_h !== 7'b1011111) begin n_err++; $display("FAIL hold_stable got %b want 1011111", seg_h); end
  endtask

  task automatic test_mid_reset();
    din = 4'd9;
    tick();
    n_cmp++;
    if (seg_h !== 7'b1111011) begin n_err++; $display("FAIL mid_reset_pre got %b want 1111011", seg_h); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (seg_h !== 7'b0000000 || seg_l !== 7'b1111111) begin
      n_err++; $display("FAIL mid_reset_async got h=%b l=%b want h=0000000 l=1111111", seg_h, seg_l);
    end
    @(negedge clk);
    din = 4'd3;
    rst = 1'b0;
    tick();
    n_cmp++;
    if (seg_h !== 7'b1111001) begin n_err++; $display("FAIL mid_reset_post got %b want 1111001", seg_h); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_invalid();
    test_priority();
    test_active_low();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
